// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller.
//   SIZE_* : req_size encodings (byte, half, word, illegal)
//   mem_state_t : controller FSM states
package mem_access_ctrl_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_X = 2'd3;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Lane decode for a 32-bit little-endian word memory.
//   rdata      : word read from memory
//   lane       : byte offset within the word (req_addr[1:0])
//   size       : access size (SIZE_B / SIZE_H / SIZE_W)
//   sign_ext   : sign-extend sub-word loads when 1
//   wdata      : right-aligned store data
//   load_data  : selected lane(s), sign- or zero-extended
//   merge_data : rdata with the addressed lane(s) replaced by wdata
module mem_access_ctrl_load_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      shifted  = rdata >> {lane, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         SIZE_B:  load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         SIZE_H:  load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
         default: load_data = rdata;
      endcase

      merge_data = rdata;
      case (size)
         SIZE_B: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
         SIZE_H: begin
            if (lane[1]) merge_data[31:16] = wdata[15:0];
            else         merge_data[15:0]  = wdata[15:0];
         end
         default: merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a word-only data memory.
// Loads complete in one cycle (registered response); word stores are single
// cycle; byte/half stores read-modify-write over two cycles with a one-cycle
// stall. Illegal accesses raise acc_err instead of touching memory.
//   clk_sys, rst_b           : clock, async active-low reset
//   req_*                    : pipeline request, held stable while stall=1
//   stall                    : hold the pipeline this cycle
//   resp_valid/rdata/rd      : registered load response
//   acc_err                  : registered pulse for an illegal request
//   MemRead/MemWrite/mem_*   : data-memory interface (combinational read)
//
// state  | meaning
// IDLE   | accept request; loads, word stores, and RMW read phase
// RMW_WR | write merged word for the held sub-word store
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MEM_AW    = 6,
   parameter int BYTE_ADDR = 32
) (
   input  logic                 clk_sys,
   input  logic                 rst_b,
   input  logic                 req_valid,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic                 req_signed,
   input  logic [BYTE_ADDR-1:0] req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   input  logic [4:0]           req_rd,
   output logic                 stall,
   output logic                 resp_valid,
   output logic [DATA_W-1:0]    resp_rdata,
   output logic [4:0]           resp_rd,
   output logic                 acc_err,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic [MEM_AW-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata
);

   mem_state_t        state_q, state_d;
   logic [DATA_W-1:0] merge_q;
   logic [DATA_W-1:0] load_data, merge_data;
   logic              bad, load_hit, err_hit, merge_ld;

   assign mem_addr = req_addr[MEM_AW+1:2];

   always_comb begin
      bad = (req_size == SIZE_X)
          | ((req_size == SIZE_H) & req_addr[0])
          | ((req_size == SIZE_W) & (req_addr[1:0] != 2'b00))
          | (req_addr[BYTE_ADDR-1:MEM_AW+2] != '0);
   end

   mem_access_ctrl_load_align u_align (
      .rdata      (mem_rdata),
      .lane       (req_addr[1:0]),
      .size       (req_size),
      .sign_ext   (req_signed),
      .wdata      (req_wdata),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      stall     = 1'b0;
      mem_wdata = req_wdata;
      load_hit  = 1'b0;
      err_hit   = 1'b0;
      merge_ld  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (bad) begin
                  err_hit = 1'b1;
               end else if (!req_write) begin
                  MemRead  = 1'b1;
                  load_hit = 1'b1;
               end else if (req_size == SIZE_W) begin
                  MemWrite = 1'b1;
               end else begin
                  MemRead  = 1'b1;
                  stall    = 1'b1;
                  merge_ld = 1'b1;
                  state_d  = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            MemWrite  = 1'b1;
            mem_wdata = merge_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset must also squash the strobes combinationally, so an RMW write
      // in flight when reset lands never reaches memory.
      if (!rst_b) begin
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         stall    = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_rd    <= '0;
         acc_err    <= 1'b0;
         merge_q    <= '0;
      end else begin
         resp_valid <= load_hit;
         acc_err    <= err_hit;
         if (load_hit) begin
            resp_rdata <= load_data;
            resp_rd    <= req_rd;
         end
         if (merge_ld) merge_q <= merge_data;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic        clk_sys = 1'b0;
   logic        rst_b;
   logic        req_valid, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        stall, resp_valid, acc_err, MemRead, MemWrite;
   logic [31:0] resp_rdata, mem_wdata, mem_rdata;
   logic [4:0]  resp_rd;
   logic [5:0]  mem_addr;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk_sys = ~clk_sys;

   mem_access_ctrl dut (
      .clk_sys    (clk_sys),
      .rst_b      (rst_b),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_rd    (resp_rd),
      .acc_err    (acc_err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk_sys) begin
      if (pl_en)         mem[pl_addr]  <= pl_data;
      else if (MemWrite) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules: plain arithmetic on byte addresses and lane masks.
   function automatic bit model_bad(input bit [1:0] sz, input bit [31:0] a);
      int nbytes;
      if (sz == 2'd3) return 1'b1;
      nbytes = 1 << sz;
      if ((a % nbytes) != 0) return 1'b1;
      if (a >= 32'd256) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit [31:0] model_load(input bit [31:0] word, input bit [31:0] a,
                                            input bit [1:0] sz, input bit sg);
      int shift, nb;
      bit [31:0] mask, v;
      if (sz == 2'd2) return word;
      shift = (a % 4) * 8;
      nb    = (sz == 2'd0) ? 8 : 16;
      mask  = (32'd1 << nb) - 32'd1;
      v     = (word >> shift) & mask;
      if (sg && v >= (32'd1 << (nb - 1))) v = v | ~mask;
      return v;
   endfunction

   function automatic bit [31:0] model_store(input bit [31:0] word, input bit [31:0] a,
                                             input bit [1:0] sz, input bit [31:0] wd);
      int shift, nb;
      bit [31:0] mask;
      if (sz == 2'd2) return wd;
      shift = (a % 4) * 8;
      nb    = (sz == 2'd0) ? 8 : 16;
      mask  = ((32'd1 << nb) - 32'd1) << shift;
      return (word & ~mask) | ((wd << shift) & mask);
   endfunction

   task automatic preload(input int a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a[5:0]; pl_data = d;
      @(posedge clk_sys); #1;
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   // Called at posedge+1; leaves at posedge+1 after the op completes.
   task automatic do_op(input bit w, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                        input bit [31:0] wd, input bit exp_err, input bit [31:0] exp_rdata,
                        input bit [31:0] exp_wword);
      bit sub, wordst;
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      sub    = w && !exp_err && (sz != 2'd2);
      wordst = w && !exp_err && (sz == 2'd2);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd; req_rd = rd;
      #3;
      chk("strobe_overlap", {31'd0, MemRead & MemWrite}, 32'd0);
      chk("stall_c1", {31'd0, stall}, {31'd0, sub});
      chk("memread_c1", {31'd0, MemRead}, {31'd0, !exp_err && (!w || sub)});
      chk("memwrite_c1", {31'd0, MemWrite}, {31'd0, wordst});
      if (!exp_err) chk("mem_addr", {26'd0, mem_addr}, {26'd0, a[7:2]});
      if (wordst) chk("sw_wdata", mem_wdata, exp_wword);
      @(posedge clk_sys); #1;
      chk("acc_err", {31'd0, acc_err}, {31'd0, exp_err});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, !w && !exp_err});
      if (!w && !exp_err) begin
         chk("resp_rdata", resp_rdata, exp_rdata);
         chk("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
      end
      if (sub) begin
         chk("stall_c2", {31'd0, stall}, 32'd0);
         chk("memwrite_c2", {31'd0, MemWrite}, 32'd1);
         chk("memread_c2", {31'd0, MemRead}, 32'd0);
         chk("rmw_wdata", mem_wdata, exp_wword);
         @(posedge clk_sys); #1;
         chk("resp_valid_rmw", {31'd0, resp_valid}, 32'd0);
         chk("acc_err_rmw", {31'd0, acc_err}, 32'd0);
      end
   endtask

   task automatic idle_cycle();
      req_valid = 1'b0;
      req_addr  = $urandom;
      #3;
      chk("idle_strobes", {29'd0, MemRead, MemWrite, stall}, 32'd0);
      @(posedge clk_sys); #1;
      chk("idle_resp", {30'd0, resp_valid, acc_err}, 32'd0);
   endtask

   typedef struct {
      bit        w;
      bit [1:0]  sz;
      bit        sg;
      bit [31:0] a;
      bit [31:0] wd;
      bit        exp_err;
      bit [31:0] exp_rdata;
      bit [31:0] exp_wword;
   } vec_t;

   vec_t vecs[11];

   initial begin
      bit        w, sg, e;
      bit [1:0]  sz;
      bit [31:0] a, wd, er, ew;

      vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,    1'b0, 32'h8899AABB, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0E,  32'h0,    1'b0, 32'hFFFFFF99, 32'h0};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0E,  32'h0,    1'b0, 32'h00000099, 32'h0};
      vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0E,  32'h0,    1'b0, 32'hFFFF8899, 32'h0};
      vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0D,  32'h55,   1'b0, 32'h0,        32'h889955BB};
      vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h0E,  32'h1234, 1'b0, 32'h0,        32'h123455BB};
      vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,    1'b0, 32'h123455BB, 32'h0};
      vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0D,  32'h0,    1'b1, 32'h0,        32'h0};
      vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h01,  32'hBEEF, 1'b1, 32'h0,        32'h0};
      vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h1111, 1'b1, 32'h0,        32'h0};
      vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0C,  32'h0,    1'b1, 32'h0,        32'h0};

      rst_b = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd3;
      repeat (2) @(posedge clk_sys);
      #1;
      chk("rst_strobes", {29'd0, MemRead, MemWrite, stall}, 32'd0);
      chk("rst_resp", {30'd0, resp_valid, acc_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_rd", {27'd0, resp_rd}, 32'd0);
      req_valid = 1'b0;
      rst_b = 1'b1;
      @(posedge clk_sys); #1;

      for (int i = 0; i < 64; i++) preload(i, $urandom);
      preload(3, 32'h8899AABB);
      preload(5, 32'hCAFEF00D);

      // Reset landing in the RMW write cycle must abandon the write.
      do_op(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFEF00D, 32'h0);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h15; req_wdata = 32'h77; req_rd = 5'd0;
      #3;
      chk("rmw_rst_stall", {31'd0, stall}, 32'd1);
      @(posedge clk_sys); #1;
      rst_b = 1'b0;
      #1;
      chk("rmw_rst_strobes", {29'd0, MemRead, MemWrite, stall}, 32'd0);
      chk("rmw_rst_resp", {30'd0, resp_valid, acc_err}, 32'd0);
      chk("rmw_rst_rdata", resp_rdata, 32'd0);
      req_valid = 1'b0;
      @(posedge clk_sys); #1;
      rst_b = 1'b1;
      chk("rmw_rst_word", mem[5], 32'hCAFEF00D);
      do_op(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFEF00D, 32'h0);

      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd,
               vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_wword);
         if (vecs[i].w && !vecs[i].exp_err) ref_mem[vecs[i].a[7:2]] = vecs[i].exp_wword;
      end
      idle_cycle();
      for (int i = 0; i < 64; i++) chk("mem_after_table", mem[i], ref_mem[i]);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 99) < 5) begin
            idle_cycle();
         end else begin
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else begin
               a = $urandom_range(0, 255);
               if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            end
            wd = $urandom;
            e  = model_bad(sz, a);
            er = 32'h0; ew = 32'h0;
            if (!e) begin
               if (w) ew = model_store(ref_mem[a / 4], a, sz, wd);
               else   er = model_load(ref_mem[a / 4], a, sz, sg);
            end
            do_op(w, sz, sg, a, wd, e, er, ew);
            if (w && !e) ref_mem[a / 4] = ew;
         end
      end
      idle_cycle();
      for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
